// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Hazard detection unit for a 5-stage MIPS pipeline, placed between the
// IF/ID and ID/EX registers. It detects load-use, branch/jr operand and
// jal-in-flight hazards. Load-use stalls can span several cycles for
// memories with latency > 1. The unit honours a global memory freeze and
// keeps a saturating count of hazard stall cycles.
//
// Parameters
//   AW        register address width
//   LOAD_LAT  stall cycles per load-use hazard (1..7)
//   NSTG      writer stages checked for branch/jr (1..3; 0=EX, 1=MEM, 2=WB)
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   id_ex_mem_read  ID/EX instruction is a load
//   id_ex_rt        load destination in ID/EX
//   if_id_rs/rt     source registers of the IF/ID instruction
//   branch          IF/ID is beq/bne (reads rs and rt)
//   jr              IF/ID is jr/jalr (reads rs only)
//   wr_en           per-stage register write enable
//   wr_addr         per-stage write address, stage i at [i*AW +: AW]
//   jal_busy        per-stage jal in flight
//   mem_stall       memory not ready, whole pipe frozen
//   perf_clr        synchronous clear of stall_cycles
//   stall           hold PC and IF/ID
//   bubble          load a NOP into ID/EX
//   haz_type        0 none, 1 load-use, 2 branch/jr operand, 3 jal in flight
//   stall_cycles    saturating count of cycles with a bubble inserted
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int NSTG     = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_ex_mem_read,
   input  logic [AW-1:0]        id_ex_rt,
   input  logic [AW-1:0]        if_id_rs,
   input  logic [AW-1:0]        if_id_rt,
   input  logic                 branch,
   input  logic                 jr,
   input  logic [NSTG-1:0]      wr_en,
   input  logic [NSTG*AW-1:0]   wr_addr,
   input  logic [NSTG-1:0]      jal_busy,
   input  logic                 mem_stall,
   input  logic                 perf_clr,
   output logic                 stall,
   output logic                 bubble,
   output logic [1:0]           haz_type,
   output logic [31:0]          stall_cycles
);

   typedef enum logic {
      S_IDLE      = 1'b0,
      S_LOAD_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic [31:0] r_stall_cycles;

   logic        w_lu_hit;
   logic        w_stg_rs;
   logic        w_stg_rt;
   logic        w_br_hit;
   logic        w_jr_hit;
   logic        w_jal_hit;
   logic        w_stall;
   logic        w_bubble;
   logic [1:0]  w_haz;

   // Register $0 is hard-wired, so a compare against it never matches.
   function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   assign w_lu_hit = id_ex_mem_read &&
                     (addr_hit(id_ex_rt, if_id_rs) || addr_hit(id_ex_rt, if_id_rt));

   always_comb begin
      w_stg_rs = 1'b0;
      w_stg_rt = 1'b0;
      for (int i = 0; i < NSTG; i++) begin
         w_stg_rs = w_stg_rs | (wr_en[i] & addr_hit(wr_addr[i*AW +: AW], if_id_rs));
         w_stg_rt = w_stg_rt | (wr_en[i] & addr_hit(wr_addr[i*AW +: AW], if_id_rt));
      end
   end

   assign w_br_hit  = branch & (w_stg_rs | w_stg_rt);
   assign w_jr_hit  = jr & w_stg_rs;
   // A control transfer in IF/ID already resolves against the jal's link
   // register through the operand compare, so jal_busy only matters otherwise.
   assign w_jal_hit = ~branch & ~jr & (|jal_busy);

   // Outputs are combinational so a hazard is blocked in the cycle it appears;
   // rst forces them low immediately, independent of the clock.
   always_comb begin
      w_haz   = 2'd0;
      w_stall = 1'b0;
      if (rst) begin
         w_haz   = 2'd0;
         w_stall = 1'b0;
      end else if (r_state == S_LOAD_WAIT) begin
         w_haz   = 2'd1;
         w_stall = 1'b1;
      end else begin
         if (w_lu_hit)                  w_haz = 2'd1;
         else if (w_br_hit | w_jr_hit)  w_haz = 2'd2;
         else if (w_jal_hit)            w_haz = 2'd3;
         w_stall = (w_haz != 2'd0);
      end
   end

   // While frozen, ID/EX keeps its contents, so no bubble is injected.
   assign w_bubble = w_stall & ~mem_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // With LOAD_LAT = 1 the bubble itself removes the load from
               // ID/EX, so no wait state is needed.
               if (w_lu_hit && !mem_stall && (LOAD_LAT > 1)) begin
                  r_state <= S_LOAD_WAIT;
                  r_cnt   <= LAT_M1;
               end
            end
            S_LOAD_WAIT: begin
               if (!mem_stall) begin
                  r_cnt <= r_cnt - 3'd1;
                  if (r_cnt == 3'd1) r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
      end else if (perf_clr) begin
         r_stall_cycles <= 32'd0;
      end else if (w_bubble && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall        = w_stall;
   assign bubble       = w_bubble;
   assign haz_type     = w_haz;
   assign stall_cycles = r_stall_cycles;

endmodule
